// File: rtl/restor_div_pkg.sv
// Shared types and helpers for the handshaked restoring divider.
package restor_div_pkg;

  // Controller states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Iteration counter width. The extra bit keeps the count from wrapping
  // inside CALC, even when only a single iteration is needed.
  function automatic int cnt_width(input int width, input int steps_per_cycle);
    return $clog2(width / steps_per_cycle) + 1;
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division step.
// The partial remainder a is always smaller than the divisor. It therefore
// fits in WIDTH bits, and only the trial subtraction needs the extra bit.
module restoring_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   shift_a;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH:0]   trial;

  // Shift {A,Q} left, trial-subtract the divisor, and restore if the result is negative.
  always_comb begin
    shift_a = {a, q[WIDTH-1]};
    shift_q = {q[WIDTH-2:0], 1'b0};
    trial   = shift_a - m;
    a_next  = shift_a[WIDTH-1:0];
    q_next  = shift_q;
    if (!trial[WIDTH]) begin
      a_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/restoring_divider_hs.sv
// Iterative restoring divider with valid/ready handshakes on input and output.
// STEPS_PER_CYCLE chained steps run per clock, so a division takes
// WIDTH/STEPS_PER_CYCLE CALC cycles.
// Optional macro RESTOR_DIV_SIGNED_EN selects two's-complement operation:
// the divider iterates on magnitudes and fixes the signs on the final edge.
module restoring_divider_hs
  import restor_div_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int K  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = cnt_width(WIDTH, STEPS_PER_CYCLE);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  if (WIDTH < 2 || STEPS_PER_CYCLE < 1 || (WIDTH % STEPS_PER_CYCLE) != 0) begin : g_param_check
    $error("restoring_divider_hs: STEPS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;

  logic [WIDTH-1:0] a_chain [0:STEPS_PER_CYCLE];
  logic [WIDTH-1:0] q_chain [0:STEPS_PER_CYCLE];

  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

`ifdef RESTOR_DIV_SIGNED_EN
  logic sign_q;
  logic sign_r;

  // The most negative value maps to its own bit pattern. Read as unsigned,
  // that pattern is the correct magnitude.
  assign op_dividend = dividend[WIDTH-1] ? -dividend : dividend;
  assign op_divisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign res_q = sign_q ? -q_chain[STEPS_PER_CYCLE] : q_chain[STEPS_PER_CYCLE];
  assign res_r = sign_r ? -a_chain[STEPS_PER_CYCLE] : a_chain[STEPS_PER_CYCLE];
`else
  assign op_dividend = dividend;
  assign op_divisor  = divisor;
  assign res_q = q_chain[STEPS_PER_CYCLE];
  assign res_r = a_chain[STEPS_PER_CYCLE];
`endif

  assign a_chain[0] = a_reg;
  assign q_chain[0] = q_reg;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    restoring_div_step #(.WIDTH(WIDTH)) u_step (
      .a      (a_chain[i]),
      .q      (q_chain[i]),
      .m      ({1'b0, m_reg}),
      .a_next (a_chain[i+1]),
      .q_next (q_chain[i+1])
    );
  end

  // Controller plus datapath registers. All handshake and result outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
`ifdef RESTOR_DIV_SIGNED_EN
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              m_reg <= op_divisor;
              q_reg <= op_dividend;
              a_reg <= '0;
              count <= '0;
`ifdef RESTOR_DIV_SIGNED_EN
              sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r <= dividend[WIDTH-1];
`endif
              state <= CALC;
            end
          end
        end
        CALC: begin
          a_reg <= a_chain[STEPS_PER_CYCLE];
          q_reg <= q_chain[STEPS_PER_CYCLE];
          count <= count + CW'(1);
          if (count == LAST) begin
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_hs.sv
// Self-checking bench for restoring_divider_hs with WIDTH=8.
// It uses two instances: one with 1 step per cycle and one with 2 steps per cycle.
// Expected results are queued when operands are issued and popped when a result appears.
module tb_restoring_divider_hs;

  localparam int W  = 8;
  localparam int K1 = 8;
  localparam int K2 = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic         in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  logic         m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_div_by_zero;
  logic [W-1:0] m_dividend, m_divisor, m_quotient, m_remainder;

  exp_t sb[$];
  exp_t sb2[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  restoring_divider_hs #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  restoring_divider_hs #(.WIDTH(W), .STEPS_PER_CYCLE(2)) dut_multi (
    .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .dividend(m_dividend), .divisor(m_divisor), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .quotient(m_quotient), .remainder(m_remainder),
    .div_by_zero(m_div_by_zero)
  );

  // Reference model: native integer division in the selected signedness.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef RESTOR_DIV_SIGNED_EN
      int sa, sd, qq, rr;
      sa = int'($signed(a));
      sd = int'($signed(b));
      qq = sa / sd;
      rr = sa % sd;
      e.q = W'(qq);
      e.r = W'(rr);
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t pop1();
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  function automatic exp_t pop2();
    exp_t e;
    e = '0;
    if (sb2.size() > 0) e = sb2.pop_front();
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    n_compared++;
    if (in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL send_wait: in_ready=%b required 1", in_ready);
    end
    dividend = a; divisor = b; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic send2(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    int guard;
    guard = 0;
    while (m_in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    n_compared++;
    if (m_in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL send2_wait: in_ready=%b required 1", m_in_ready);
    end
    m_dividend = a; m_divisor = b; m_in_valid = 1'b1;
    sb2.push_back(e);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
  endtask

  task automatic wait_out2(output int lat);
    lat = 1;
    while (m_out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_compared++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b, expected rdy=1 vld=0 q=00 r=00 dz=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    n_compared++;
    if ({m_in_ready, m_out_valid, m_quotient, m_remainder, m_div_by_zero} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state_multi: got rdy=%b vld=%b q=%h r=%h dz=%b, expected rdy=1 vld=0 q=00 r=00 dz=0",
               m_in_ready, m_out_valid, m_quotient, m_remainder, m_div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int   lat;
    exp_t e;
    send(8'd100, 8'd7, '{q: 8'd14, r: 8'd2, dz: 1'b0});
    wait_out(lat);
    n_compared++;
    if (lat !== K1 + 1) begin
      n_mismatched++;
      $display("[TB] FAIL basic_latency: got %0d, expected %0d", lat, K1 + 1);
    end
    e = pop1();
    n_compared++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      n_mismatched++;
      $display("[TB] FAIL basic_result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    retire();
  endtask

  task automatic test_div_zero();
    int   lat;
    exp_t e;
    send(8'h55, 8'h00, '{q: 8'hFF, r: 8'h55, dz: 1'b1});
    wait_out(lat);
    n_compared++;
    if (lat !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL dz_latency: got %0d, expected 1", lat);
    end
    e = pop1();
    n_compared++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      n_mismatched++;
      $display("[TB] FAIL dz_result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    retire();
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    send(8'd120, 8'd9, '{q: 8'd13, r: 8'd3, dz: 1'b0});
    wait_out(lat);
    n_compared++;
    if (lat !== K1 + 1) begin
      n_mismatched++;
      $display("[TB] FAIL bp_latency: got %0d, expected %0d", lat, K1 + 1);
    end
    e = pop1();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      dividend = 8'd1;
      divisor  = 8'd1;
      @(posedge clk); #1;
      n_compared++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, e}) begin
        n_mismatched++;
        $display("[TB] FAIL bp_hold[%0d]: got vld=%b rdy=%b q=%h r=%h dz=%b, expected vld=1 rdy=0 q=%h r=%h dz=%b",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
    end
    in_valid = 1'b0;
    retire();
    n_compared++;
    if ({in_ready, out_valid, quotient, remainder} !== {1'b1, 1'b0, e.q, e.r}) begin
      n_mismatched++;
      $display("[TB] FAIL bp_retire: got rdy=%b vld=%b q=%h r=%h, expected rdy=1 vld=0 q=%h r=%h",
               in_ready, out_valid, quotient, remainder, e.q, e.r);
    end
    repeat (2) begin @(posedge clk); #1; end
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL bp_no_stray: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    int   lat;
    exp_t e;
    send(8'd200, 8'd3, '0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    sb.delete();
    n_compared++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset: got rdy=%b vld=%b q=%h r=%h dz=%b, expected rdy=1 vld=0 q=00 r=00 dz=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    send(8'd50, 8'd5, '{q: 8'd10, r: 8'd0, dz: 1'b0});
    wait_out(lat);
    n_compared++;
    if (lat !== K1 + 1) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_latency: got %0d, expected %0d", lat, K1 + 1);
    end
    e = pop1();
    n_compared++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    int           lat;
    exp_t         e;
    logic [W-1:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom_range(0, 255));
      b = (i == 3) ? 8'h00 : W'($urandom_range(1, 255));
      send(a, b, model(a, b));
      wait_out(lat);
      n_compared++;
      if (lat !== ((b == 0) ? 1 : K1 + 1)) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_latency[%0d]: got %0d, expected %0d", i, lat, (b == 0) ? 1 : K1 + 1);
      end
      e = pop1();
      n_compared++;
      if ({quotient, remainder, div_by_zero} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_result[%0d] %h/%h: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                 i, a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      @(posedge clk); #1;
      n_compared++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_retire[%0d]: got rdy=%b vld=%b, expected rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_multi_step();
    int   lat;
    exp_t e;
    send2(8'd255, 8'd1, '{q: 8'd255, r: 8'd0, dz: 1'b0});
    wait_out2(lat);
    n_compared++;
    if (lat !== K2 + 1) begin
      n_mismatched++;
      $display("[TB] FAIL multi_latency: got %0d, expected %0d", lat, K2 + 1);
    end
    e = pop2();
    n_compared++;
    if ({m_quotient, m_remainder, m_div_by_zero} !== e) begin
      n_mismatched++;
      $display("[TB] FAIL multi_255_1: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
               m_quotient, m_remainder, m_div_by_zero, e.q, e.r, e.dz);
    end
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_out_ready = 1'b0;
    send2(8'd3, 8'd200, '{q: 8'd0, r: 8'd3, dz: 1'b0});
    wait_out2(lat);
    e = pop2();
    n_compared++;
    if ({m_quotient, m_remainder, m_div_by_zero} !== e) begin
      n_mismatched++;
      $display("[TB] FAIL multi_3_200: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
               m_quotient, m_remainder, m_div_by_zero, e.q, e.r, e.dz);
    end
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    m_out_ready = 1'b0;
  endtask

`ifdef RESTOR_DIV_SIGNED_EN
  task automatic test_signed();
    int   lat;
    exp_t e;
    exp_t cases [3];
    logic [W-1:0] ops [3][2];
    cases[0] = '{q: 8'hFD, r: 8'hFF, dz: 1'b0}; ops[0][0] = 8'hF9; ops[0][1] = 8'h02;
    cases[1] = '{q: 8'hFD, r: 8'h01, dz: 1'b0}; ops[1][0] = 8'h07; ops[1][1] = 8'hFE;
    cases[2] = '{q: 8'h80, r: 8'h00, dz: 1'b0}; ops[2][0] = 8'h80; ops[2][1] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      send(ops[i][0], ops[i][1], cases[i]);
      wait_out(lat);
      e = pop1();
      n_compared++;
      if ({quotient, remainder, div_by_zero} !== e) begin
        n_mismatched++;
        $display("[TB] FAIL signed[%0d] %h/%h: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                 i, ops[i][0], ops[i][1], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
      retire();
    end
  endtask
`endif

  // Run every scenario in order, then print the summary line.
  initial begin
    in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_dividend = '0; m_divisor = '0;
    $display("[TB] starting restoring_divider_hs bench");
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_multi_step();
`ifdef RESTOR_DIV_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
